// File: rtl/san_counter_pkg.sv
// san_counter_pkg: shared state type and widths for the san_counter timer datapath
package san_counter_pkg;
   localparam int CNT_W_DEF    = 32;
   localparam int PRESC_W_DEF  = 16;
   localparam int TC_COUNT_W   = 8;
   localparam int TC_COUNT_MAX = 255;
   typedef enum logic [1:0] {IDLE, RUN, DONE} cnt_state_t;
endpackage

// File: rtl/san_counter_presc.sv
// san_counter_presc: prescaler producing a tick every div+1 enabled cycles
module san_counter_presc
   import san_counter_pkg::*;
#(
   parameter int PRESC_W = PRESC_W_DEF
) (
   input  logic               ACLK,
   input  logic               ARESETN,
   input  logic               enable,
   input  logic               clear,
   input  logic [PRESC_W-1:0] div,
   output logic               tick
);
   logic [PRESC_W-1:0] presc_cnt;
   assign tick = enable && (presc_cnt == div);
   // div may shrink below presc_cnt mid-run: the >= wraps without a tick
   always_ff @(posedge ACLK)
      if (!ARESETN || clear) presc_cnt <= '0;
      else if (enable) presc_cnt <= (presc_cnt >= div) ? '0 : presc_cnt + PRESC_W'(1);
endmodule

// File: rtl/san_counter_core.sv
// san_counter_core: timer/counter datapath with run FSM, prescaler and terminal-count status.
// Optional edge capture of the live count is enabled by defining SAN_COUNTER_CAPTURE_EN.
module san_counter_core
   import san_counter_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int PRESC_W = PRESC_W_DEF
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic                  ctrl_start,
   input  logic                  ctrl_stop,
   input  logic                  ctrl_oneshot,
   input  logic                  ctrl_down,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [CNT_W-1:0]      ld_value,
   input  logic [CNT_W-1:0]      tc_value,
   input  logic [PRESC_W-1:0]    presc_div,
   input  logic                  clr_status,
   output logic [CNT_W-1:0]      count,
   output logic                  running,
   output logic                  tc_flag,
   output logic                  tc_pulse,
   output logic [TC_COUNT_W-1:0] tc_count
`ifdef SAN_COUNTER_CAPTURE_EN
   ,
   input  logic                  cap_in,
   output logic [CNT_W-1:0]      cap_value,
   output logic                  cap_valid
`endif
);
   cnt_state_t state, state_nxt;
   logic tick, hit, tc_event, enter_run;
   logic [CNT_W-1:0] count_nxt;
   assign ld_ready  = 1'b1;
   assign running   = (state == RUN);
   assign enter_run = ctrl_start && !ctrl_stop && (state != RUN);
   san_counter_presc #(.PRESC_W(PRESC_W)) u_presc (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .enable  (state == RUN),
      .clear   (enter_run || ld_valid),
      .div     (presc_div),
      .tick    (tick)
   );
   always_comb begin
      hit       = ctrl_down ? (count == '0) : (count == tc_value);
      tc_event  = tick && !ld_valid && hit;
      state_nxt = state;
      if (ctrl_stop && (state == RUN || ctrl_start)) state_nxt = IDLE;
      else if (enter_run) state_nxt = RUN;
      else if (tc_event && ctrl_oneshot) state_nxt = DONE;
      // oneshot terminal holds: count already equals tc_value (up) or 0 (down)
      count_nxt = count;
      if (ld_valid) count_nxt = ld_value;
      else if (tick) count_nxt = hit ? (ctrl_oneshot ? count : (ctrl_down ? tc_value : '0))
                                     : (ctrl_down ? count - CNT_W'(1) : count + CNT_W'(1));
   end
   always_ff @(posedge ACLK)
      if (!ARESETN) begin
         state    <= IDLE;
         count    <= '0;
         tc_pulse <= 1'b0;
         tc_flag  <= 1'b0;
         tc_count <= '0;
      end else begin
         state    <= state_nxt;
         count    <= count_nxt;
         tc_pulse <= tc_event;
         tc_flag  <= tc_event || (tc_flag && !clr_status);
         if (tc_event) tc_count <= clr_status ? TC_COUNT_W'(1)
                                  : (tc_count == TC_COUNT_W'(TC_COUNT_MAX)) ? tc_count : tc_count + TC_COUNT_W'(1);
         else if (clr_status) tc_count <= '0;
      end
`ifdef SAN_COUNTER_CAPTURE_EN
   logic [2:0] cap_sync;
   logic cap_edge;
   assign cap_edge = cap_sync[1] && !cap_sync[2];
   always_ff @(posedge ACLK)
      if (!ARESETN) begin
         cap_sync  <= '0;
         cap_value <= '0;
         cap_valid <= 1'b0;
      end else begin
         cap_sync  <= {cap_sync[1:0], cap_in};
         if (cap_edge) cap_value <= count;
         cap_valid <= cap_edge || (cap_valid && !clr_status);
      end
`endif
endmodule

// File: tb/tb_san_counter_core.sv
// tb_san_counter_core: directed and randomized checks of san_counter_core against a behavioural model.
// Capture checks run only when SAN_COUNTER_CAPTURE_EN is defined.
module tb_san_counter_core;
   logic        ACLK = 1'b0, ARESETN = 1'b0;
   logic        ctrl_start = 1'b0, ctrl_stop = 1'b0, ctrl_oneshot = 1'b0, ctrl_down = 1'b0;
   logic        ld_valid = 1'b0, clr_status = 1'b0;
   logic [31:0] ld_value = '0, tc_value = '0;
   logic [15:0] presc_div = '0;
   logic        ld_ready, running, tc_flag, tc_pulse;
   logic [31:0] count;
   logic [7:0]  tc_count;
`ifdef SAN_COUNTER_CAPTURE_EN
   logic        cap_in = 1'b0, cap_valid;
   logic [31:0] cap_value;
`endif
   int n_assert = 0, n_fail = 0;
   // model: m_state 0 = idle, 1 = run, 2 = done
   int          m_state = 0, m_pre = 0, m_tcc = 0;
   logic [31:0] m_count = '0;
   bit          m_flag = 0, m_pulse = 0;

   always #5 ACLK = ~ACLK;

   san_counter_core dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop),
      .ctrl_oneshot(ctrl_oneshot), .ctrl_down(ctrl_down), .ld_valid(ld_valid), .ld_ready(ld_ready),
      .ld_value(ld_value), .tc_value(tc_value), .presc_div(presc_div), .clr_status(clr_status),
      .count(count), .running(running), .tc_flag(tc_flag), .tc_pulse(tc_pulse), .tc_count(tc_count)
`ifdef SAN_COUNTER_CAPTURE_EN
      , .cap_in(cap_in), .cap_value(cap_value), .cap_valid(cap_valid)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("count", count, m_count);
      chk("running", 32'(running), 32'(m_state == 1));
      chk("tc_flag", 32'(tc_flag), 32'(m_flag));
      chk("tc_pulse", 32'(tc_pulse), 32'(m_pulse));
      chk("tc_count", 32'(tc_count), 32'(m_tcc));
      chk("ld_ready", 32'(ld_ready), 32'd1);
   endtask

   // advance one clock: model consumes the inputs present at the edge
   task automatic cyc();
      bit tick, hit, ev;
      int ns, np, nt;
      logic [31:0] nc;
      tick = (m_state == 1) && (m_pre == int'(presc_div));
      hit  = ctrl_down ? (m_count == 0) : (m_count == tc_value);
      ev   = tick && !ld_valid && hit;
      nc = m_count;
      if (ld_valid) nc = ld_value;
      else if (tick && !hit) nc = ctrl_down ? m_count - 1 : m_count + 1;
      else if (tick && !ctrl_oneshot) nc = ctrl_down ? tc_value : 0;
      np = m_pre;
      if (ld_valid || (m_state != 1 && ctrl_start && !ctrl_stop)) np = 0;
      else if (m_state == 1) np = (m_pre >= int'(presc_div)) ? 0 : m_pre + 1;
      ns = m_state;
      if (ctrl_stop && (m_state == 1 || ctrl_start)) ns = 0;
      else if (ctrl_start && m_state != 1) ns = 1;
      else if (ev && ctrl_oneshot) ns = 2;
      nt = (clr_status ? 0 : m_tcc) + int'(ev);
      if (nt > 255) nt = 255;
      @(posedge ACLK);
      #1;
      if (!ARESETN) begin
         m_state = 0; m_pre = 0; m_tcc = 0; m_count = 0; m_flag = 0; m_pulse = 0;
      end else begin
         m_state = ns; m_pre = np; m_tcc = nt; m_count = nc;
         m_flag = ev || (m_flag && !clr_status);
         m_pulse = ev;
      end
      check_all();
   endtask

   initial begin
      logic [31:0] up_exp [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
      // reset
      ARESETN = 1'b0;
      cyc(); cyc();
      chk("rst_count", count, 0);
      chk("rst_running", 32'(running), 0);
      chk("rst_ld_ready", 32'(ld_ready), 1);
      ARESETN = 1'b1;
      cyc();
      // up periodic, every-cycle tick, terminal at 3
      tc_value = 3; presc_div = 0;
      ctrl_start = 1; cyc(); ctrl_start = 0;
      chk("up_start_count", count, 0);
      for (int i = 0; i < 8; i++) begin
         cyc();
         chk("up_seq", count, up_exp[i]);
         chk("up_pulse", 32'(tc_pulse), 32'((i % 4) == 3));
      end
      chk("up_flag", 32'(tc_flag), 1);
      chk("up_tc_count", 32'(tc_count), 2);
      ctrl_stop = 1; cyc(); ctrl_stop = 0;
      chk("stop_running", 32'(running), 0);
      clr_status = 1; cyc(); clr_status = 0;
      chk("clr_flag", 32'(tc_flag), 0);
      chk("clr_tc_count", 32'(tc_count), 0);
      // down oneshot, tick every 5 cycles, from 2
      ctrl_down = 1; ctrl_oneshot = 1; presc_div = 4;
      ld_valid = 1; ld_value = 2; cyc(); ld_valid = 0;
      chk("dn_load", count, 2);
      ctrl_start = 1; cyc(); ctrl_start = 0;
      for (int i = 1; i <= 15; i++) begin
         cyc();
         chk("dn_count", count, (i < 5) ? 2 : (i < 10) ? 1 : 0);
         chk("dn_pulse", 32'(tc_pulse), 32'(i == 15));
         chk("dn_running", 32'(running), 32'(i < 15));
      end
      repeat (6) cyc();
      chk("dn_hold", count, 0);
      chk("dn_done_running", 32'(running), 0);
      chk("dn_tc_count", 32'(tc_count), 1);
      // load coinciding with tick
      ctrl_down = 0; ctrl_oneshot = 0; presc_div = 0; tc_value = 32'h1000;
      ctrl_start = 1; cyc(); ctrl_start = 0;
      ld_valid = 1; ld_value = 32'h100; cyc(); ld_valid = 0;
      chk("ld_tick_count", count, 32'h100);
      chk("ld_tick_pulse", 32'(tc_pulse), 0);
      cyc();
      chk("ld_after_count", count, 32'h101);
      // start and stop together
      ctrl_stop = 1; cyc(); ctrl_stop = 0;
      ctrl_start = 1; ctrl_stop = 1; cyc(); ctrl_start = 0; ctrl_stop = 0;
      chk("startstop_running", 32'(running), 0);
      cyc();
      chk("startstop_idle", 32'(running), 0);
      // clr_status with terminal event, then saturation
      tc_value = 0; ld_valid = 1; ld_value = 0; cyc(); ld_valid = 0;
      ctrl_start = 1; cyc(); ctrl_start = 0;
      clr_status = 1; cyc(); clr_status = 0;
      chk("clr_ev_flag", 32'(tc_flag), 1);
      chk("clr_ev_tc_count", 32'(tc_count), 1);
      repeat (300) cyc();
      chk("sat_tc_count", 32'(tc_count), 255);
      // reset mid-run for one edge
      ARESETN = 0; cyc(); ARESETN = 1;
      chk("mid_rst_count", count, 0);
      chk("mid_rst_running", 32'(running), 0);
      chk("mid_rst_flag", 32'(tc_flag), 0);
      chk("mid_rst_pulse", 32'(tc_pulse), 0);
      chk("mid_rst_tc_count", 32'(tc_count), 0);
      cyc();
`ifdef SAN_COUNTER_CAPTURE_EN
      ld_valid = 1; ld_value = 7; cyc(); ld_valid = 0;
      cap_in = 1; repeat (3) cyc();
      chk("cap_value", cap_value, 7);
      chk("cap_valid", 32'(cap_valid), 1);
      cap_in = 0; clr_status = 1; cyc(); clr_status = 0;
      chk("cap_clr", 32'(cap_valid), 0);
`endif
      // randomized traffic
      repeat (800) begin
         ctrl_start   = ($urandom_range(0, 7) == 0);
         ctrl_stop    = ($urandom_range(0, 15) == 0);
         ld_valid     = ($urandom_range(0, 15) == 0);
         clr_status   = ($urandom_range(0, 15) == 0);
         ld_value     = $urandom_range(0, 25);
         if ($urandom_range(0, 31) == 0) begin
            ctrl_oneshot = 1'($urandom_range(0, 1));
            ctrl_down    = 1'($urandom_range(0, 1));
            tc_value     = $urandom_range(0, 20);
         end
         if ($urandom_range(0, 15) == 0) presc_div = 16'($urandom_range(0, 3));
         ARESETN = ($urandom_range(0, 199) != 0);
         cyc();
      end
      ARESETN = 1; ctrl_start = 0; ctrl_stop = 0; ld_valid = 0; clr_status = 0;
      cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
